fp_addsub_issue: RTL and testbench

Sequential issue/retire stage wrapped around the combinational FP32 `adder_subtracter`.
- Accepts IEEE-754 single-precision operand pairs with an add/sub opcode over a valid/ready handshake and buffers them in a small FIFO.
- Drives the adder's `x1`/`x2` inputs, folding subtract into a sign flip of `x2`, then holds them stable for a settle window and captures `x3`.
- Overrides special cases (NaN, infinity, inf−inf) and presents a registered result with flags downstream over valid/ready.

---
 rtl/fp_addsub_issue.sv | 171 +++++++++++++++++
 tb/tb_fp_addsub_issue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_issue.sv
// Issue/retire stage around a combinational FP32 adder: buffers operand pairs,
// drives x1/x2 for a fixed settle window, then captures x3 with special-case handling.
module fp_addsub_issue #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic [31:0] x1,
    output logic [31:0] x2,
    input  logic [31:0] x3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic        busy
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(SETTLE + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Operand FIFO: {sub, a, b} per entry
    logic [64:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [64:0]      head;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      x1_reg;
    logic [31:0]      x2_reg;
    logic             out_valid_reg;
    logic [31:0]      out_result_reg;
    logic [3:0]       out_flags_reg;

    assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign in_ready   = !fifo_full && !rst;
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr_reg];

    // A new operation is loaded straight from IDLE, or on the retiring handshake in HOLD
    assign pop = !fifo_empty &&
                 ((state_reg == ST_IDLE) ||
                  (state_reg == ST_HOLD && out_valid_reg && out_ready));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_sub, in_a, in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Special-case classification on the operands actually presented to the adder
    logic        x1_nan;
    logic        x2_nan;
    logic        x1_inf;
    logic        x2_inf;
    logic [31:0] cap_result;
    logic [3:0]  cap_flags;

    assign x1_nan = (x1_reg[30:23] == 8'hFF) && (x1_reg[22:0] != 23'd0);
    assign x2_nan = (x2_reg[30:23] == 8'hFF) && (x2_reg[22:0] != 23'd0);
    assign x1_inf = (x1_reg[30:23] == 8'hFF) && (x1_reg[22:0] == 23'd0);
    assign x2_inf = (x2_reg[30:23] == 8'hFF) && (x2_reg[22:0] == 23'd0);

    always_comb begin
        cap_result = x3;
        cap_flags  = {1'b0, (x3[30:23] == 8'hFF), (x3[30:0] == 31'd0), 1'b0};
        if (x1_nan || x2_nan) begin
            cap_result = QNAN;
            cap_flags  = 4'b1000;
        end else if (x1_inf && x2_inf && (x1_reg[31] != x2_reg[31])) begin
            cap_result = QNAN;
            cap_flags  = 4'b1001;
        end else if (x1_inf) begin
            cap_result = x1_reg;
            cap_flags  = 4'b0100;
        end else if (x2_inf) begin
            cap_result = x2_reg;
            cap_flags  = 4'b0100;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            x1_reg         <= '0;
            x2_reg         <= '0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_flags_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_reg <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg > CNT_W'(1)) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        out_result_reg <= cap_result;
                        out_flags_reg  <= cap_flags;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= fifo_empty ? ST_IDLE : ST_SETTLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Subtract is folded into a sign flip of the second operand
            if (pop) begin
                x1_reg  <= head[63:32];
                x2_reg  <= head[64] ? {~head[31], head[30:0]} : head[31:0];
                cnt_reg <= CNT_W'(SETTLE);
            end
        end
    end

    assign x1         = x1_reg;
    assign x2         = x2_reg;
    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_flags  = out_flags_reg;
    assign busy       = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Scoreboard bench for fp_addsub_issue; x3 comes from a stand-in adder model.
module tb_fp_addsub_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] x3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        busy;

    typedef struct {
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t exp_q[$];
    int   pop_log[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    fp_addsub_issue #(.DEPTH(4), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .x1(x1), .x2(x2), .x3(x3),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in adder: exact cancellation gives +0, otherwise an arbitrary but deterministic value
    function automatic logic [31:0] adder_stub(input logic [31:0] p, input logic [31:0] q);
        if (p[30:0] == q[30:0] && p[31] != q[31]) return 32'h0;
        return p + q;
    endfunction

    assign x3 = adder_stub(x1, x2);

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        logic [31:0] y;
        logic na, nb, ia, ib;
        y  = s ? {~b[31], b[30:0]} : b;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        e.x1 = a;
        e.x2 = y;
        if (na || nb) begin
            e.res = 32'h7FC00000; e.flg = 4'b1000;
        end else if (ia && ib && a[31] != y[31]) begin
            e.res = 32'h7FC00000; e.flg = 4'b1001;
        end else if (ia) begin
            e.res = a; e.flg = 4'b0100;
        end else if (ib) begin
            e.res = y; e.flg = 4'b0100;
        end else begin
            e.res = adder_stub(a, y);
            e.flg = {1'b0, e.res[30:23] == 8'hFF, e.res[30:0] == 0, 1'b0};
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Monitor: sampled mid-low-phase, after the driver has settled its inputs
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                check("result", out_result, exp_q[0].res);
                check("flags", 32'(out_flags), 32'(exp_q[0].flg));
                if (out_ready) begin
                    check("x1", x1, exp_q[0].x1);
                    check("x2", x2, exp_q[0].x2);
                    $display("xfer cyc=%0d x1=%h x2=%h result=%h flags=%b",
                             cyc, x1, x2, out_result, out_flags);
                    pop_log.push_back(cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic acc;
        int tries;
        acc = 0;
        tries = 0;
        in_a = a; in_b = b; in_sub = s; in_valid = 1;
        while (!acc && tries < 50) begin
            acc = in_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(model(a, b, s));
            else begin
                tries++;
                @(negedge clk);
            end
        end
        if (!acc) check("push_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int acc_n;
        logic r;
        logic [31:0] va, vb;
        rst = 0; in_valid = 0; in_a = 0; in_b = 0; in_sub = 0; out_ready = 1;
        #1 rst = 1;
        #1;
        check("rst_x1", x1, 0);
        check("rst_x2", x2, 0);
        check("rst_result", out_result, 0);
        check("rst_flags", 32'(out_flags), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        #1 check("in_ready_after_rst", 32'(in_ready), 1);
        @(negedge clk);

        // Latency: out_valid after edge E0+3
        push(32'h40490FDB, 32'h409570A4, 1'b0);
        check("lat_e0", 32'(out_valid), 0);
        @(negedge clk);
        check("lat_e1", 32'(out_valid), 0);
        check("lat_x1", x1, 32'h40490FDB);
        check("lat_x2", x2, 32'h409570A4);
        @(negedge clk);
        check("lat_e2", 32'(out_valid), 0);
        @(negedge clk);
        check("lat_e3", 32'(out_valid), 1);
        wait_drain();

        push(32'h4048F5C3, 32'h4048F5C3, 1'b1);
        push(32'h7F800000, 32'h7F800000, 1'b0);
        push(32'h7F800000, 32'hFF800000, 1'b0);
        push(32'h7F800001, 32'h40108A3D, 1'b0);
        push(32'h7F800000, 32'h40108A3D, 1'b1);
        wait_drain();

        // Backpressure: DEPTH+1 pairs in flight, then drain at one per SETTLE+1 cycles
        out_ready = 0;
        acc_n = 0;
        for (int c = 0; c < 10; c++) begin
            va = 32'h3F800000 + 32'(acc_n << 20);
            vb = 32'h40000000 + 32'(acc_n << 18);
            in_a = va; in_b = vb; in_sub = acc_n[0]; in_valid = 1;
            r = in_ready;
            @(posedge clk);
            if (r) begin
                exp_q.push_back(model(va, vb, acc_n[0]));
                acc_n++;
            end
            @(negedge clk);
        end
        in_valid = 0;
        check("bp_accepted", 32'(acc_n), 5);
        check("bp_in_ready", 32'(in_ready), 0);
        pop_log.delete();
        out_ready = 1;
        wait_drain();
        check("bp_results", 32'(pop_log.size()), 5);
        for (int i = 1; i < pop_log.size(); i++)
            check("bp_spacing", 32'(pop_log[i] - pop_log[i-1]), 3);

        // Random mix with occasional special exponents
        for (int i = 0; i < 10; i++) begin
            va = $urandom;
            vb = $urandom;
            if ($urandom_range(0, 3) == 0) va[30:23] = 8'hFF;
            if ($urandom_range(0, 3) == 0) vb[30:23] = 8'hFF;
            push(va, vb, 1'($urandom_range(0, 1)));
        end
        wait_drain();

        // Reset mid-SETTLE with two entries queued
        push(32'h40400000, 32'h3F800000, 1'b0);
        push(32'h40800000, 32'h3F800000, 1'b1);
        push(32'h40A00000, 32'h3F800000, 1'b0);
        rst = 1;
        #1;
        exp_q.delete();
        check("mid_rst_x1", x1, 0);
        check("mid_rst_x2", x2, 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (8) @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_valid", 32'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
